// File: rtl/ntt_pkg.sv
// Shared types and helpers for the ML-KEM coefficient shuffle path.
// Holds the shuffle mode enum, the skid-buffer state enum and LOG_H helper.
package ntt_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        INTT   = 2'd1,
        NTT    = 2'd2,
        RSVD   = 2'd3
    } shuffle_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // LOG_H = log2(HALF_NUM_BFU)
    function automatic int log_h(input int h);
        return $clog2(h);
    endfunction

endpackage

// File: rtl/lane_permute_net.sv
// Combinational coefficient permutation: bypass, INTT de-interleave, NTT re-interleave.
// Ports: i_mode, i_log_g (clamped to LOG_H), i_a/i_b in, o_a/o_b permuted out.
module lane_permute_net
    import ntt_pkg::*;
#(
    parameter  int HALF_NUM_BFU = 16,
    parameter  int DATA_W       = 16,
    localparam int N            = 2 * HALF_NUM_BFU,
    localparam int LOG_H        = log_h(HALF_NUM_BFU),
    localparam int LGW          = $clog2(LOG_H + 1)
) (
    input  logic [1:0]                 i_mode,
    input  logic [LGW-1:0]             i_log_g,
    input  logic [N-1:0][DATA_W-1:0]   i_a,
    input  logic [N-1:0][DATA_W-1:0]   i_b,
    output logic [N-1:0][DATA_W-1:0]   o_a,
    output logic [N-1:0][DATA_W-1:0]   o_b
);

    localparam int H = HALF_NUM_BFU;

    logic [LGW-1:0] w_lg;

    // Mux chain over legal group sizes; the last stage holds the selection
    logic [N-1:0][DATA_W-1:0] w_sel_ia [LOG_H+1];
    logic [N-1:0][DATA_W-1:0] w_sel_ib [LOG_H+1];
    logic [N-1:0][DATA_W-1:0] w_sel_na [LOG_H+1];
    logic [N-1:0][DATA_W-1:0] w_sel_nb [LOG_H+1];

    assign w_lg = (i_log_g > LGW'(LOG_H)) ? LGW'(LOG_H) : i_log_g;

    for (genvar gi = 0; gi <= LOG_H; gi++) begin : g_grp
        localparam int G = 1 << gi;

        logic [N-1:0][DATA_W-1:0] w_ia;
        logic [N-1:0][DATA_W-1:0] w_ib;
        logic [N-1:0][DATA_W-1:0] w_na;
        logic [N-1:0][DATA_W-1:0] w_nb;

        for (genvar j = 0; j < H; j++) begin : g_lane
            // k(j) = (j/G)*2G + (j mod G)
            localparam int K = (j / G) * 2 * G + (j % G);

            assign w_ia[j]     = i_a[K];
            assign w_ia[j+H]   = i_b[K];
            assign w_ib[j]     = i_a[K+G];
            assign w_ib[j+H]   = i_b[K+G];

            assign w_na[K]     = i_a[j];
            assign w_na[K+G]   = i_b[j];
            assign w_nb[K]     = i_a[j+H];
            assign w_nb[K+G]   = i_b[j+H];
        end

        if (gi == 0) begin : g_first
            assign w_sel_ia[gi] = w_ia;
            assign w_sel_ib[gi] = w_ib;
            assign w_sel_na[gi] = w_na;
            assign w_sel_nb[gi] = w_nb;
        end else begin : g_next
            logic w_hit;
            assign w_hit        = (w_lg == LGW'(gi));
            assign w_sel_ia[gi] = w_hit ? w_ia : w_sel_ia[gi-1];
            assign w_sel_ib[gi] = w_hit ? w_ib : w_sel_ib[gi-1];
            assign w_sel_na[gi] = w_hit ? w_na : w_sel_na[gi-1];
            assign w_sel_nb[gi] = w_hit ? w_nb : w_sel_nb[gi-1];
        end
    end

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        unique case (i_mode)
            INTT: begin
                o_a = w_sel_ia[LOG_H];
                o_b = w_sel_ib[LOG_H];
            end
            NTT: begin
                o_a = w_sel_na[LOG_H];
                o_b = w_sel_nb[LOG_H];
            end
            default: begin
                // BYPASS and the reserved code both pass through
                o_a = i_a;
                o_b = i_b;
            end
        endcase
    end

endmodule

// File: rtl/lane_shuffle_pipe.sv
// Registered lane shuffle with a 2-entry valid/ready skid buffer (flopped o_ready).
// Ports: i_clk, i_rst_n, i_valid/o_ready, i_mode, i_log_g, i_a/i_b, o_valid/i_ready, o_a/o_b, o_busy.
module lane_shuffle_pipe
    import ntt_pkg::*;
#(
    parameter  int HALF_NUM_BFU = 16,
    parameter  int DATA_W       = 16,
    localparam int N            = 2 * HALF_NUM_BFU,
    localparam int LOG_H        = log_h(HALF_NUM_BFU),
    localparam int LGW          = $clog2(LOG_H + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [1:0]                 i_mode,
    input  logic [LGW-1:0]             i_log_g,
    input  logic [N-1:0][DATA_W-1:0]   i_a,
    input  logic [N-1:0][DATA_W-1:0]   i_b,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [N-1:0][DATA_W-1:0]   o_a,
    output logic [N-1:0][DATA_W-1:0]   o_b,
    output logic                       o_busy
);

    skid_state_e              r_state;
    logic                     r_valid;
    logic                     r_ready;
    logic                     r_busy;
    logic [N-1:0][DATA_W-1:0] r_main_a;
    logic [N-1:0][DATA_W-1:0] r_main_b;
    logic [N-1:0][DATA_W-1:0] r_skid_a;
    logic [N-1:0][DATA_W-1:0] r_skid_b;

    logic                     w_in;
    logic                     w_out;
    logic [N-1:0][DATA_W-1:0] w_pa;
    logic [N-1:0][DATA_W-1:0] w_pb;

    assign w_in  = i_valid && r_ready;
    assign w_out = r_valid && i_ready;

    lane_permute_net #(
        .HALF_NUM_BFU (HALF_NUM_BFU),
        .DATA_W       (DATA_W)
    ) u_perm (
        .i_mode  (i_mode),
        .i_log_g (i_log_g),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_a     (w_pa),
        .o_b     (w_pb)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_EMPTY;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_main_a <= '0;
            r_main_b <= '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        r_state  <= ST_ONE;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_main_a <= w_pa;
                        r_main_b <= w_pb;
                    end
                end
                ST_ONE: begin
                    if (w_in && !w_out) begin
                        // New beat parks in the skid register
                        r_state <= ST_FULL;
                        r_ready <= 1'b0;
                    end else if (w_in && w_out) begin
                        r_main_a <= w_pa;
                        r_main_b <= w_pb;
                    end else if (w_out) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out) begin
                        r_state  <= ST_ONE;
                        r_ready  <= 1'b1;
                        r_main_a <= r_skid_a;
                        r_main_b <= r_skid_b;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skid data is only meaningful in ST_FULL, so it needs no reset
    always_ff @(posedge i_clk) begin
        if (r_state == ST_ONE && w_in && !w_out) begin
            r_skid_a <= w_pa;
            r_skid_b <= w_pb;
        end
    end

    assign o_valid = r_valid;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_a     = r_main_a;
    assign o_b     = r_main_b;

endmodule

// File: tb/tb_lane_shuffle_pipe.sv
// Self-checking bench for lane_shuffle_pipe with H=4, DATA_W=16.
// Scoreboard monitor plus per-scenario directed checks.
module tb_lane_shuffle_pipe;

    localparam int H   = 4;
    localparam int N   = 8;
    localparam int DW  = 16;
    localparam int LGW = 2;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct packed {
        vec_t a;
        vec_t b;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [1:0]     i_mode = 2'd0;
    logic [LGW-1:0] i_log_g = '0;
    vec_t           i_a = '0;
    vec_t           i_b = '0;
    logic           o_valid;
    logic           i_ready = 1'b1;
    vec_t           o_a;
    vec_t           o_b;
    logic           o_busy;

    int checks = 0;
    int errors = 0;

    beat_t sb[$];
    logic  prev_hold = 1'b0;
    vec_t  prev_a;
    vec_t  prev_b;

    vec_t base_a;
    vec_t base_b;

    always #5 clk = ~clk;

    lane_shuffle_pipe #(
        .HALF_NUM_BFU (H),
        .DATA_W       (DW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_log_g (i_log_g),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_busy  (o_busy)
    );

    function automatic beat_t model(vec_t a, vec_t b, logic [1:0] m, int lg);
        beat_t r;
        int g;
        int k;
        if (lg > 2) lg = 2;
        g = 1 << lg;
        r.a = a;
        r.b = b;
        if (m == 2'd1) begin
            for (int j = 0; j < H; j++) begin
                k = (j / g) * 2 * g + (j % g);
                r.a[j]   = a[k];
                r.a[j+H] = b[k];
                r.b[j]   = a[k+g];
                r.b[j+H] = b[k+g];
            end
        end else if (m == 2'd2) begin
            for (int j = 0; j < H; j++) begin
                k = (j / g) * 2 * g + (j % g);
                r.a[k]   = a[j];
                r.a[k+g] = b[j];
                r.b[k]   = a[j+H];
                r.b[k+g] = b[j+H];
            end
        end
        return r;
    endfunction

    function automatic vec_t to_vec(input int v[8]);
        vec_t r;
        for (int j = 0; j < N; j++) r[j] = DW'(v[j]);
        return r;
    endfunction

    // Scoreboard: push on accept, pop on emit, and output-stability check
    always @(negedge clk) begin
        beat_t exp_b;
        if (!rst_n) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (o_valid !== 1'b1 || o_a !== prev_a || o_b !== prev_b) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b a=%h b=%h required v=1 a=%h b=%h",
                             o_valid, o_a, o_b, prev_a, prev_b);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got a=%h b=%h required no beat", o_a, o_b);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_a !== exp_b.a || o_b !== exp_b.b) begin
                        errors++;
                        $display("FAIL sb_data: got a=%h b=%h required a=%h b=%h",
                                 o_a, o_b, exp_b.a, exp_b.b);
                    end
                end
            end
            if (i_valid && o_ready)
                sb.push_back(model(i_a, i_b, i_mode, int'(i_log_g)));
            prev_hold = o_valid && !i_ready;
            prev_a = o_a;
            prev_b = o_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b r=%b busy=%b required 0 1 0",
                     o_valid, o_ready, o_busy);
        end
        checks++;
        if (o_a !== '0 || o_b !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h required 0", o_a, o_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_intt_g1();
        vec_t ea;
        vec_t eb;
        for (int j = 0; j < H; j++) begin
            ea[j]   = DW'(2 * j);
            ea[j+H] = DW'(8 + 2 * j);
            eb[j]   = DW'(2 * j + 1);
            eb[j+H] = DW'(9 + 2 * j);
        end
        i_ready = 1'b1;
        i_a = base_a;
        i_b = base_b;
        i_mode = 2'd1;
        i_log_g = 2'd0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL intt_g1_valid: got v=%b busy=%b required 1 1", o_valid, o_busy);
        end
        checks++;
        if (o_a !== ea || o_b !== eb) begin
            errors++;
            $display("FAIL intt_g1_data: got a=%h b=%h required a=%h b=%h", o_a, o_b, ea, eb);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL intt_g1_drain: got v=%b required 0", o_valid);
        end
    endtask

    task automatic test_intt_g2_clamp();
        int   a2[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
        int   b2[8] = '{2, 3, 6, 7, 10, 11, 14, 15};
        int   a4[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
        int   b4[8] = '{4, 5, 6, 7, 12, 13, 14, 15};
        int   lg7   = 7;
        vec_t ea;
        vec_t eb;
        i_ready = 1'b1;
        i_a = base_a;
        i_b = base_b;
        i_mode = 2'd1;
        i_log_g = 2'd1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        ea = to_vec(a2);
        eb = to_vec(b2);
        checks++;
        if (o_a !== ea || o_b !== eb) begin
            errors++;
            $display("FAIL intt_g2_data: got a=%h b=%h required a=%h b=%h", o_a, o_b, ea, eb);
        end
        i_log_g = lg7[LGW-1:0];
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        ea = to_vec(a4);
        eb = to_vec(b4);
        checks++;
        if (o_a !== ea || o_b !== eb) begin
            errors++;
            $display("FAIL intt_clamp_data: got a=%h b=%h required a=%h b=%h", o_a, o_b, ea, eb);
        end
        tick();
    endtask

    task automatic test_ntt_roundtrip();
        vec_t ta;
        vec_t tb;
        i_ready = 1'b1;
        for (int lg = 0; lg < 3; lg++) begin
            i_a = base_a;
            i_b = base_b;
            i_mode = 2'd1;
            i_log_g = LGW'(lg);
            i_valid = 1'b1;
            tick();
            ta = o_a;
            tb = o_b;
            i_a = ta;
            i_b = tb;
            i_mode = 2'd2;
            tick();
            i_valid = 1'b0;
            checks++;
            if (o_a !== base_a || o_b !== base_b) begin
                errors++;
                $display("FAIL ntt_roundtrip_g%0d: got a=%h b=%h required a=%h b=%h",
                         1 << lg, o_a, o_b, base_a, base_b);
            end
            tick();
        end
        i_a = base_a;
        i_b = base_b;
        i_mode = 2'd3;
        i_log_g = 2'd1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_a !== base_a || o_b !== base_b) begin
            errors++;
            $display("FAIL rsvd_bypass: got a=%h b=%h required a=%h b=%h",
                     o_a, o_b, base_a, base_b);
        end
        tick();
    endtask

    task automatic test_backpressure();
        vec_t v1;
        vec_t v2;
        vec_t v3;
        for (int j = 0; j < N; j++) begin
            v1[j] = DW'(16'h100 + j);
            v2[j] = DW'(16'h200 + j);
            v3[j] = DW'(16'h300 + j);
        end
        i_ready = 1'b0;
        i_mode = 2'd0;
        i_log_g = 2'd0;
        i_a = v1;
        i_b = ~v1;
        i_valid = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one: got v=%b r=%b required 1 1", o_valid, o_ready);
        end
        i_a = v2;
        i_b = ~v2;
        tick();
        checks++;
        if (o_ready !== 1'b0 || o_a !== v1) begin
            errors++;
            $display("FAIL bp_full: got r=%b a=%h required r=0 a=%h", o_ready, o_a, v1);
        end
        i_a = v3;
        i_b = ~v3;
        tick();
        checks++;
        if (o_ready !== 1'b0 || o_a !== v1 || o_b !== ~v1) begin
            errors++;
            $display("FAIL bp_hold: got r=%b a=%h required r=0 a=%h", o_ready, o_a, v1);
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_a !== v2) begin
            errors++;
            $display("FAIL bp_release: got r=%b v=%b a=%h required r=1 v=1 a=%h",
                     o_ready, o_valid, o_a, v2);
        end
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_a !== v3) begin
            errors++;
            $display("FAIL bp_third: got v=%b a=%h required v=1 a=%h", o_valid, o_a, v3);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got v=%b busy=%b required 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_random();
        int  cnt;
        logic acc;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_valid = 1'b0;
                i_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            for (int j = 0; j < N; j++) begin
                i_a[j] = DW'($urandom);
                i_b[j] = DW'($urandom);
            end
            i_mode = 2'($urandom_range(0, 3));
            i_log_g = LGW'($urandom_range(0, 3));
            i_valid = 1'b1;
            cnt = 0;
            do begin
                acc = o_ready;
                i_ready = ($urandom_range(0, 2) != 0);
                tick();
                cnt++;
            end while (!acc && cnt < 100);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL rand_accept_timeout: got no accept after %0d cycles required accept", cnt);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        cnt = 0;
        while ((sb.size() != 0 || o_valid) && cnt < 20) begin
            tick();
            cnt++;
        end
        tick();
        checks++;
        if (sb.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got pending=%0d v=%b required 0 0", sb.size(), o_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        i_ready = 1'b0;
        i_mode = 2'd0;
        i_a = base_a;
        i_b = base_b;
        i_valid = 1'b1;
        tick();
        i_a = base_b;
        i_b = base_a;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_full: got r=%b v=%b required 0 1", o_ready, o_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b r=%b busy=%b required 0 1 0",
                     o_valid, o_ready, o_busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        i_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale: got stale beat required none");
        end
        i_a = base_a;
        i_b = base_b;
        i_mode = 2'd2;
        i_log_g = 2'd0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (sb.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got pending=%0d v=%b required 0 0", sb.size(), o_valid);
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            base_a[j] = DW'(j);
            base_b[j] = DW'(j + 8);
        end
        test_reset();
        test_intt_g1();
        test_intt_g2_clamp();
        test_ntt_roundtrip();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_shuffle_pipe.md
# lane_shuffle_pipe

Registered, mode- and stride-programmable coefficient shuffle for the ML-KEM butterfly array. Each beat carries two vectors of 2·HALF_NUM_BFU coefficients (`a`, `b`). The block applies one of three permutations, chosen per beat: bypass, INTT de-interleave or NTT re-interleave. The interleave group size is 2^`i_log_g`. The block sits between the coefficient RAM read port and the BFU array, and decouples the two with a valid/ready skid buffer whose `o_ready` is driven from a flop.

## Interface
- `HALF_NUM_BFU`, default 16: half the lane count. Power of two, ≥2. H = HALF_NUM_BFU, N = 2H, LOG_H = $clog2(H).
- `DATA_W`, default 16: coefficient width.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  input beat accepted when `i_valid && o_ready`. Driven from a flop.
- `i_mode`  in  2  0 = BYPASS, 1 = INTT, 2 = NTT, 3 = reserved (treated as BYPASS).
- `i_log_g`  in  $clog2(LOG_H+1)  log2 of the group size G. Values above LOG_H clamp to LOG_H.
- `i_a`, `i_b`  in  DATA_W × N each  input vectors.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts the output beat when `o_valid && i_ready`.
- `o_a`, `o_b`  out  DATA_W × N each  permuted vectors.
- `o_busy`  out  1  high while at least one beat is held.

## Operation
- Index helper: for j in 0..H-1, k(j) = (j/G)·2G + (j mod G).
- **INTT mode**, for every j:
  - o_a[j] = a[k(j)], o_a[j+H] = b[k(j)]
  - o_b[j] = a[k(j)+G], o_b[j+H] = b[k(j)+G]
  - G=1 gives the plain even/odd de-interleave.
- **NTT mode** is the exact inverse of INTT mode, for every j:
  - o_a[k(j)] = a[j], o_a[k(j)+G] = b[j]
  - o_b[k(j)] = a[j+H], o_b[k(j)+G] = b[j+H]
- **BYPASS mode:** o_a = a, o_b = b.
- `i_mode` and `i_log_g` are sampled with the beat. The permutation is applied before capture, so stored entries hold already-permuted data.
- **Storage:** 2-entry skid buffer, a main register plus a skid register.
- **State machine:**
  - EMPTY: `o_valid`=0, `o_ready`=1.
  - ONE: main register full; `o_valid`=1, `o_ready`=1.
  - FULL: both registers full; `o_valid`=1, `o_ready`=0.
- **Transitions** (in = `i_valid && o_ready`, out = `o_valid && i_ready`):
  - EMPTY + in → ONE.
  - ONE + in + !out → FULL; the new beat goes to the skid register.
  - ONE + in + out → ONE; the main register is replaced.
  - ONE + !in + out → EMPTY.
  - FULL + out → ONE; skid moves to main.
  - Otherwise the state holds.
- **Ordering:** beats leave in acceptance order. No beat is dropped or duplicated.
- **Output stability:** `o_a`/`o_b` do not change while `o_valid && !i_ready`.

## Timing
- **Reset:** on `i_rst_n`=0, asynchronously: state = EMPTY, `o_valid`=0, `o_ready`=1, `o_busy`=0. `o_a`/`o_b` reset to 0. Skid data registers are not reset.
- **Reset mid-operation:** all held beats are discarded. Nothing is emitted after reset is released until a new beat is accepted.
- **Latency:** 1 cycle. A beat accepted at edge t is visible on `o_*` after edge t.
- **Throughput:** 1 beat/cycle sustained while `i_ready`=1.
- `o_ready` falls the cycle after the second unconsumed beat is taken. It never depends combinationally on `i_ready`.
- **Simultaneous in and out in state ONE:** the main register takes the new beat. The state stays ONE with no bubble.

## Structure
- **Package `ntt_pkg`:** the `shuffle_mode_e` enum (BYPASS/INTT/NTT/RSVD) and the `LOG_H` helper function.
- **Sub-module `lane_permute_net`:** purely combinational. Inputs are mode, log_g and the a/b vectors; outputs are the permuted a/b vectors. G is implemented as a mux over its LOG_H+1 legal values.
- **Top level:** skid buffer and state machine.

## Test plan
All scenarios use H=4 and DATA_W=16, with a = 0..7 and b = 8..15.
- **INTT, G=1, i_ready=1:** o_a = {0,2,4,6,8,10,12,14}, o_b = {1,3,5,7,9,11,13,15}, one cycle after acceptance.
- **INTT, G=2:** o_a = {0,1,4,5,8,9,12,13}, o_b = {2,3,6,7,10,11,14,15}. Also i_log_g=7 must give the same output as G=4: o_a = {0..3, 8..11}.
- **NTT round-trip:** feed INTT G=1 output back with NTT, G=1 → a = 0..7, b = 8..15 exactly. Repeat for G=2 and G=4. Mode 3 behaves as bypass.
- **Backpressure:** i_ready=0, push 3 beats → first two accepted; `o_ready`=0 after the second; output held stable. Release i_ready → beats emerge in order, then the third is accepted.
- **Random valid/ready:** 1000 beats with random modes, scoreboarded against a reference model → no loss, duplication or reordering. Every output change coincides with a handshake.
- **Reset mid-operation:** hold state FULL, assert i_rst_n=0 → `o_valid`=0 and `o_ready`=1 immediately. After release no stale beat appears.
